// File: rtl/stripe_scheduler.sv
// Stripe scheduler: walks a query against 64-base reference stripes, feeding the
// PE array, draining its enable chain and reporting one result per stripe.
module stripe_scheduler #(
  parameter int LEN_W     = 10,
  parameter int STR_W     = 6,
  parameter int DRAIN_CYC = 65
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_job_valid,
  output logic               o_job_ready,
  input  logic [LEN_W-1:0]   i_job_len,
  input  logic [STR_W-1:0]   i_job_stripes,
  output logic [LEN_W-1:0]   o_a_addr,
  input  logic [1:0]         i_a_data,
  output logic [STR_W-1:0]   o_b_addr,
  input  logic [127:0]       i_b_data,
  output logic               o_pe_start,
  output logic [1:0]         o_pe_A,
  output logic [127:0]       o_pe_B,
  input  logic               i_pe_stripe_end,
  input  logic [LEN_W-1:0]   i_pe_end_position,
  output logic               o_res_valid,
  output logic [STR_W-1:0]   o_res_stripe,
  output logic               o_res_early,
  output logic [LEN_W-1:0]   o_res_end_pos,
  output logic               o_busy,
  output logic               o_done
);

  localparam int DR_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len;
  logic [STR_W-1:0]  r_stripes;
  logic [STR_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_feed;
  logic [DR_W-1:0]   r_drain;
  logic              r_early;
  logic [LEN_W-1:0]  r_pos;
  logic              w_more;
  logic              w_capture;

  // Widened by one bit so the stripe-count comparison can never wrap.
  assign w_more    = ({1'b0, r_idx} + {{STR_W{1'b0}}, 1'b1}) < {1'b0, r_stripes};
  assign w_capture = i_pe_stripe_end && !r_early &&
                     ((r_state == S_FEED) || (r_state == S_DRAIN));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_job_valid) begin
          if ((i_job_len == {LEN_W{1'b0}}) || (i_job_stripes == {STR_W{1'b0}})) begin
            w_next = S_DONE;
          end else begin
            w_next = S_FETCH;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_FETCH: w_next = S_FEED;
      S_FEED: begin
        if (i_pe_stripe_end || (r_feed == (r_len - {{(LEN_W-1){1'b0}}, 1'b1}))) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_FEED;
        end
      end
      S_DRAIN: begin
        if (r_drain == {{(DR_W-1){1'b0}}, 1'b1}) begin
          w_next = S_REPORT;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_REPORT: begin
        if (w_more) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job parameters, counters and early-termination capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len     <= {LEN_W{1'b0}};
      r_stripes <= {STR_W{1'b0}};
      r_idx     <= {STR_W{1'b0}};
      r_feed    <= {LEN_W{1'b0}};
      r_drain   <= {DR_W{1'b0}};
      r_early   <= 1'b0;
      r_pos     <= {LEN_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_job_valid) begin
            r_len     <= i_job_len;
            r_stripes <= i_job_stripes;
            r_idx     <= {STR_W{1'b0}};
            r_early   <= 1'b0;
            r_pos     <= {LEN_W{1'b0}};
          end
        end
        S_FETCH: r_feed <= {LEN_W{1'b0}};
        S_FEED: begin
          r_feed <= r_feed + {{(LEN_W-1){1'b0}}, 1'b1};
          if (w_next == S_DRAIN) begin
            r_drain <= DR_W'(DRAIN_CYC);
          end
        end
        S_DRAIN: r_drain <= r_drain - {{(DR_W-1){1'b0}}, 1'b1};
        S_REPORT: begin
          if (w_more) begin
            r_idx   <= r_idx + {{(STR_W-1){1'b0}}, 1'b1};
            r_early <= 1'b0;
            r_pos   <= {LEN_W{1'b0}};
          end
        end
        default: begin
        end
      endcase
      // Only the first pulse of a stripe is kept.
      if (w_capture) begin
        r_early <= 1'b1;
        r_pos   <= i_pe_end_position;
      end
    end
  end

  // Outputs are decoded from registered state so the memory data path stays aligned.
  assign o_job_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_pe_start    = (r_state == S_FEED);
  assign o_pe_A        = (r_state == S_FEED) ? i_a_data : 2'b00;
  assign o_pe_B        = (r_state == S_FEED) ? i_b_data : {128{1'b0}};
  assign o_a_addr      = (r_state == S_FEED) ? (r_feed + {{(LEN_W-1){1'b0}}, 1'b1}) : {LEN_W{1'b0}};
  assign o_b_addr      = ((r_state == S_FETCH) || (r_state == S_FEED)) ? r_idx : {STR_W{1'b0}};
  assign o_res_valid   = (r_state == S_REPORT);
  assign o_res_stripe  = (r_state == S_REPORT) ? r_idx : {STR_W{1'b0}};
  assign o_res_early   = (r_state == S_REPORT) ? r_early : 1'b0;
  assign o_res_end_pos = (r_state == S_REPORT) ? (r_early ? r_pos : r_len) : {LEN_W{1'b0}};

endmodule

// File: tb/tb_stripe_scheduler.sv
// Directed bench for stripe_scheduler: memories modelled with one-cycle read latency,
// every check an immediate assertion against hand-computed values.
module tb_stripe_scheduler;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_job_valid;
  logic         o_job_ready;
  logic [9:0]   i_job_len;
  logic [5:0]   i_job_stripes;
  logic [9:0]   o_a_addr;
  logic [1:0]   i_a_data;
  logic [5:0]   o_b_addr;
  logic [127:0] i_b_data;
  logic         o_pe_start;
  logic [1:0]   o_pe_A;
  logic [127:0] o_pe_B;
  logic         i_pe_stripe_end;
  logic [9:0]   i_pe_end_position;
  logic         o_res_valid;
  logic [5:0]   o_res_stripe;
  logic         o_res_early;
  logic [9:0]   o_res_end_pos;
  logic         o_busy;
  logic         o_done;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  stripe_scheduler dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_len(i_job_len), .i_job_stripes(i_job_stripes), .o_a_addr(o_a_addr),
    .i_a_data(i_a_data), .o_b_addr(o_b_addr), .i_b_data(i_b_data), .o_pe_start(o_pe_start),
    .o_pe_A(o_pe_A), .o_pe_B(o_pe_B), .i_pe_stripe_end(i_pe_stripe_end),
    .i_pe_end_position(i_pe_end_position), .o_res_valid(o_res_valid),
    .o_res_stripe(o_res_stripe), .o_res_early(o_res_early), .o_res_end_pos(o_res_end_pos),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [1:0] amem(input logic [9:0] a);
    return a[1:0] ^ a[3:2] ^ a[5:4];
  endfunction

  function automatic logic [127:0] bmem(input logic [5:0] s);
    return {32{s[3:0] ^ 4'h5}};
  endfunction

  // Synchronous-read query and reference memories
  always @(posedge i_clk) begin
    i_a_data <= amem(o_a_addr);
    i_b_data <= bmem(o_b_addr);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [9:0] len, input logic [5:0] str);
    i_job_len     = len;
    i_job_stripes = str;
    i_job_valid   = 1'b1;
    tick();
    i_job_valid   = 1'b0;
  endtask

  task automatic wait_res(input int bound, output int cnt);
    cnt = 0;
    while (!o_res_valid && cnt < bound) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_job_valid = 1'b0; i_job_len = 10'd0; i_job_stripes = 6'd0;
    i_pe_stripe_end = 1'b0; i_pe_end_position = 10'd0;
    #2;
    chk("rst_ready", o_job_ready, 1);
    chk("rst_start", o_pe_start, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_a_addr", o_a_addr, 0);
    chk("rst_b_addr", o_b_addr, 0);
    chk("rst_pe_B", o_pe_B, 0);
    chk("rst_end_pos", o_res_end_pos, 0);
    tick(); tick();
    i_rst = 1'b0;
    tick();

    // len=5, one stripe, no early end
    start_job(10'd5, 6'd1);
    chk("j1_fetch_busy", o_busy, 1);
    chk("j1_fetch_ready", o_job_ready, 0);
    chk("j1_fetch_b_addr", o_b_addr, 0);
    chk("j1_fetch_a_addr", o_a_addr, 0);
    chk("j1_fetch_start", o_pe_start, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("j1_feed_start", o_pe_start, 1);
      chk("j1_feed_a_addr", o_a_addr, 10'(k + 1));
      chk("j1_feed_pe_A", o_pe_A, amem(10'(k)));
      chk("j1_feed_pe_B", o_pe_B, bmem(6'd0));
    end
    tick();
    chk("j1_drain_start", o_pe_start, 0);
    chk("j1_drain_pe_A", o_pe_A, 0);
    chk("j1_drain_pe_B", o_pe_B, 0);
    wait_res(200, n);
    chk("j1_drain_len", n, 65);
    chk("j1_res_stripe", o_res_stripe, 0);
    chk("j1_res_early", o_res_early, 0);
    chk("j1_res_end", o_res_end_pos, 5);
    tick();
    chk("j1_done", o_done, 1);
    tick();
    chk("j1_done_clear", o_done, 0);
    chk("j1_ready", o_job_ready, 1);

    // len=300, three stripes; a stray request in stripe 1 is ignored
    start_job(10'd300, 6'd3);
    for (int s = 0; s < 3; s++) begin
      chk("j2_fetch_b_addr", o_b_addr, 6'(s));
      chk("j2_fetch_start", o_pe_start, 0);
      if (s == 1) begin
        i_job_valid = 1'b1; i_job_len = 10'd7; i_job_stripes = 6'd1;
      end else begin
        i_job_valid = 1'b0;
      end
      tick();
      chk("j2_feed_pe_B", o_pe_B, bmem(6'(s)));
      chk("j2_feed_ready", o_job_ready, 0);
      wait_res(500, n);
      chk("j2_report_time", n, 365);
      chk("j2_res_stripe", o_res_stripe, 6'(s));
      chk("j2_res_early", o_res_early, 0);
      chk("j2_res_end", o_res_end_pos, 300);
      tick();
    end
    i_job_valid = 1'b0;
    chk("j2_done", o_done, 1);
    tick();

    // len=400, early end at position 120
    start_job(10'd400, 6'd1);
    for (int k = 0; k < 121; k++) tick();
    chk("j3_feed_a_addr", o_a_addr, 121);
    chk("j3_feed_start", o_pe_start, 1);
    i_pe_stripe_end = 1'b1; i_pe_end_position = 10'd120;
    tick();
    i_pe_stripe_end = 1'b0;
    chk("j3_stop_start", o_pe_start, 0);
    wait_res(200, n);
    chk("j3_drain_len", n, 65);
    chk("j3_res_early", o_res_early, 1);
    chk("j3_res_end", o_res_end_pos, 120);
    tick();
    chk("j3_done", o_done, 1);
    tick();

    // Two pulses in stripe 0 (50 in FEED, 70 in DRAIN); stripe 1 has none
    start_job(10'd100, 6'd2);
    for (int k = 0; k < 11; k++) tick();
    i_pe_stripe_end = 1'b1; i_pe_end_position = 10'd50;
    tick();
    chk("j4_stop_start", o_pe_start, 0);
    i_pe_end_position = 10'd70;
    tick();
    i_pe_stripe_end = 1'b0;
    wait_res(200, n);
    chk("j4_drain_len", n, 64);
    chk("j4_res0_early", o_res_early, 1);
    chk("j4_res0_end", o_res_end_pos, 50);
    tick();
    chk("j4_fetch_b_addr", o_b_addr, 1);
    wait_res(300, n);
    chk("j4_res1_time", n, 166);
    chk("j4_res1_stripe", o_res_stripe, 1);
    chk("j4_res1_early", o_res_early, 0);
    chk("j4_res1_end", o_res_end_pos, 100);
    tick();
    chk("j4_done", o_done, 1);
    tick();

    // Degenerate jobs go straight to DONE
    start_job(10'd0, 6'd2);
    chk("j5_done", o_done, 1);
    chk("j5_start", o_pe_start, 0);
    chk("j5_res_valid", o_res_valid, 0);
    tick();
    chk("j5_ready", o_job_ready, 1);
    start_job(10'd5, 6'd0);
    chk("j6_done", o_done, 1);
    chk("j6_res_valid", o_res_valid, 0);
    tick();
    chk("j6_ready", o_job_ready, 1);

    // Asynchronous reset mid-FEED, then a fresh job
    start_job(10'd50, 6'd2);
    for (int k = 0; k < 10; k++) tick();
    chk("j7_feed_start", o_pe_start, 1);
    i_rst = 1'b1;
    #1;
    chk("j7_rst_start", o_pe_start, 0);
    chk("j7_rst_ready", o_job_ready, 1);
    chk("j7_rst_busy", o_busy, 0);
    chk("j7_rst_a_addr", o_a_addr, 0);
    tick();
    i_rst = 1'b0;
    tick();
    start_job(10'd5, 6'd1);
    chk("j8_fetch_b_addr", o_b_addr, 0);
    wait_res(200, n);
    chk("j8_report_time", n, 71);
    chk("j8_res_stripe", o_res_stripe, 0);
    chk("j8_res_early", o_res_early, 0);
    chk("j8_res_end", o_res_end_pos, 5);
    tick();
    chk("j8_done", o_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stripe_scheduler.md
STRIPE_SCHEDULER -- requirements
Module: stripe_scheduler

Interface
REQ-001 Parameter LEN_W, default 10: width of query length, A address and end position.
REQ-002 Parameter STR_W, default 6: width of stripe count and stripe index.
REQ-003 Parameter DRAIN_CYC, default 65: cycles waited after start deasserts so the 64-PE enable chain empties.
REQ-004 i_clk  in  1  clock; all state changes on the rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_job_valid  in  1  job request.
REQ-007 o_job_ready  out  1  high only in IDLE; a job is accepted when i_job_valid & o_job_ready.
REQ-008 i_job_len  in  LEN_W  query (A) length in bases.
REQ-009 i_job_stripes  in  STR_W  number of 64-base reference stripes.
REQ-010 o_a_addr  out  LEN_W  query memory address; data is valid one cycle later.
REQ-011 i_a_data  in  2  query base.
REQ-012 o_b_addr  out  STR_W  reference stripe memory address; data is valid one cycle later.
REQ-013 i_b_data  in  128  64 reference bases, base i in bits [2i+1:2i].
REQ-014 o_pe_start  out  1  array start/enable, held high for the stripe feed window.
REQ-015 o_pe_A  out  2  query base to the array.
REQ-016 o_pe_B  out  128  reference stripe to the array.
REQ-017 i_pe_stripe_end  in  1  array early-termination pulse.
REQ-018 i_pe_end_position  in  LEN_W  array termination position, valid with i_pe_stripe_end.
REQ-019 o_res_valid  out  1  one-cycle result pulse per stripe; no backpressure.
REQ-020 o_res_stripe  out  STR_W  stripe index of the result.
REQ-021 o_res_early  out  1  1 when the stripe terminated early.
REQ-022 o_res_end_pos  out  LEN_W  captured i_pe_end_position when early, otherwise i_job_len.
REQ-023 o_busy  out  1  high in every state except IDLE.
REQ-024 o_done  out  1  one-cycle pulse when a job completes.

Function
REQ-025 The FSM SHALL have the states IDLE, FETCH, FEED, DRAIN, REPORT and DONE.
REQ-026 On job acceptance, the block SHALL latch len and stripes, clear stripe index and early flag, and go to FETCH; if len==0 or stripes==0 it SHALL go to DONE instead.
REQ-027 FETCH SHALL last 1 cycle, driving o_b_addr=stripe index and o_a_addr=0, then go to FEED with the feed counter at 0.
REQ-028 In FEED, o_pe_start=1, o_pe_B=i_b_data, o_pe_A=i_a_data, and o_a_addr=feed counter+1; the feed counter SHALL increment each cycle.
REQ-029 FEED SHALL exit to DRAIN after exactly len cycles, or on the cycle after i_pe_stripe_end is sampled high; o_pe_start SHALL be 0 in the following cycle.
REQ-030 On entering DRAIN, the drain counter SHALL load DRAIN_CYC; DRAIN SHALL last exactly DRAIN_CYC cycles, then go to REPORT.
REQ-031 When i_pe_stripe_end is high in FEED or DRAIN, the block SHALL set the early flag and capture i_pe_end_position.
- Only the first pulse per stripe is captured; later pulses are ignored.
- A pulse in DRAIN does not shorten the drain.
REQ-032 REPORT SHALL last 1 cycle, asserting o_res_valid with index, early flag and end position.
- If index+1 < stripes: increment index, clear early flag, go to FETCH.
- Otherwise: go to DONE.
REQ-033 DONE SHALL last 1 cycle with o_done=1, then go to IDLE.
REQ-034 Outside FEED, o_pe_start SHALL be 0, and o_pe_A and o_pe_B SHALL be 0.
REQ-035 i_job_valid outside IDLE SHALL be ignored; latched job parameters SHALL NOT change during a job.
REQ-036 All counter comparisons SHALL be unsigned; the stripe index SHALL NOT wrap, since it stops at stripes-1.

Reset
REQ-037 On i_rst (asynchronous, active-high), including mid-job, the block SHALL go to IDLE and clear all counters, the early flag and the captured position.
REQ-038 Reset values: o_job_ready=1, o_pe_start=0, o_pe_A=0, o_pe_B=0, o_a_addr=0, o_b_addr=0, o_res_valid=0, o_res_stripe=0, o_res_early=0, o_res_end_pos=0, o_busy=0, o_done=0.

Verification
REQ-039 len=5, stripes=1, no early end -> o_pe_start high 5 cycles, o_a_addr 1..5, result {0, early=0, end=5}, o_done 1+5+65+1 cycles after FETCH.
REQ-040 len=300, stripes=3 -> three o_res_valid pulses with stripes 0, 1, 2, o_b_addr 0, 1, 2 in FETCH, o_done after the third REPORT.
REQ-041 len=400, i_pe_stripe_end with position 120 in FEED cycle 121 -> o_pe_start low next cycle, 65-cycle drain, result {early=1, end=120}.
REQ-042 Two stripe_end pulses in one stripe (positions 50 and 70) -> end=50 reported; the next stripe reports early=0 when it has no pulse.
REQ-043 len=0 or stripes=0 -> FETCH not entered, o_pe_start stays 0, no o_res_valid, o_done one cycle after acceptance.
REQ-044 i_rst in FEED cycle 10 -> o_pe_start=0 immediately, IDLE, o_job_ready=1; a new job after reset runs correctly.
